// File: rtl/restador_serial_nbit_pkg.sv
// Purpose: shared definitions for the serial adder/subtractor (FSM states, operation codes, cycle count).
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package restador_serial_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sel encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of RUN cycles needed to cover a WIDTH-bit operand CHUNK bits at a time.
    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/restador_serial_nbit_if.sv
// Purpose: request/result bundle between a requester and the serial adder/subtractor.
// Latency: wires only.
// Backpressure: none in the bundle; the requester watches busy/done and re-asserts start.
// Ports: start/A/B/Sel from the requester; busy/done/salida/Co/Z/N/V from the arithmetic unit.
interface restador_serial_nbit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] salida;
    logic             Co;
    logic             Z;
    logic             N;
    logic             V;

    modport master (
        output start, A, B, Sel,
        input  busy, done, salida, Co, Z, N, V
    );

    modport slave (
        input  start, A, B, Sel,
        output busy, done, salida, Co, Z, N, V
    );
endinterface

// File: rtl/restador_serial_nbit_sum_chunk.sv
// Purpose: CHUNK-bit ripple-carry adder slice used once per cycle by the serial unit.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: a/b/ci operands and carry-in; sum, cout, and msb_ci (carry into the top bit, for overflow).
module restador_serial_nbit_sum_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_ci
);
    import restador_serial_nbit_pkg::*;

    // Ripple carry held in a scalar that is updated bit by bit, so no
    // vector feeds back into itself.
    logic c;

    always_comb begin
        c      = ci;
        sum    = '0;
        msb_ci = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                msb_ci = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/restador_serial_nbit.sv
// Purpose: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one ripple slice.
// Latency: K+1 edges from accepted start to done (K = WIDTH/CHUNK); one result per K+1 cycles.
// Backpressure: start is ignored while busy; no queueing, requester must retry after done.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start/A/B/Sel in and
//        busy/done/salida/Co/Z/N/V out. Result and flags hold until the next completion.
module restador_serial_nbit
    import restador_serial_nbit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                  clk,
    input logic                  rst,
    restador_serial_nbit_if.slave bus
);

    localparam int K  = chunk_count(WIDTH, CHUNK);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_param_check
            $fatal(1, "restador_serial_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;      // operand A, shifted right one chunk per RUN cycle
    logic [WIDTH-1:0] b_q;      // operand B already inverted for subtraction, shifted likewise
    logic [WIDTH-1:0] res;      // partial result, filled from the top down
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] salida_q;
    logic             co_q;
    logic             z_q;
    logic             n_q;
    logic             v_q;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_msb_ci;
    logic [WIDTH-1:0] res_next;

    restador_serial_nbit_sum_chunk #(
        .CHUNK (CHUNK)
    ) u_sum_chunk (
        .a      (a_q[CHUNK-1:0]),
        .b      (b_q[CHUNK-1:0]),
        .ci     (carry),
        .sum    (chunk_sum),
        .cout   (chunk_cout),
        .msb_ci (chunk_msb_ci)
    );

    // Each new chunk enters at the top and older chunks move down, so after
    // K cycles chunk 0 sits at bit 0 and the register holds the full result.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign res_next = chunk_sum;
        end else begin : g_multi
            assign res_next = {chunk_sum, res[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            salida_q <= '0;
            co_q     <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B ^ {WIDTH{bus.Sel}};
                        // Carry-in of 1 completes the two's complement of B.
                        carry  <= bus.Sel;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    res   <= res_next;
                    carry <= chunk_cout;
                    if (cnt == LAST) begin
                        state    <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        salida_q <= res_next;
                        co_q     <= chunk_cout;
                        z_q      <= (res_next == '0);
                        n_q      <= res_next[WIDTH-1];
                        v_q      <= chunk_cout ^ chunk_msb_ci;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.salida = salida_q;
    assign bus.Co     = co_q;
    assign bus.Z      = z_q;
    assign bus.N      = n_q;
    assign bus.V      = v_q;

endmodule

// File: tb/tb_restador_serial_nbit.sv
// Purpose: self-checking bench for restador_serial_nbit at WIDTH=8, CHUNK=2 (K=4).
// Latency: expects done K+1 edges after the accepting edge.
// Backpressure: drives start only when the unit can accept, except where ignoring is under test.
module tb_restador_serial_nbit;
    import restador_serial_nbit_pkg::*;

    localparam int W = 8;
    localparam int C = 2;
    localparam int K = 4;

    typedef struct packed {
        logic [W-1:0] salida;
        logic         co;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    restador_serial_nbit_if #(.WIDTH(W)) bus ();

    restador_serial_nbit #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Reference: plain modulo arithmetic with flags from unsigned/signed comparisons.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
        exp_t       e;
        logic [W-1:0] r;
        logic [W:0]   wide;
        if (sel == OP_SUB) begin
            r    = a - b;
            e.co = (a >= b);
            e.v  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[W-1:0];
            e.co = wide[W];
            e.v  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        e.salida = r;
        e.z      = (r == '0);
        e.n      = r[W-1];
        return e;
    endfunction

    function automatic exp_t observed();
        return {bus.salida, bus.Co, bus.Z, bus.N, bus.V};
    endfunction

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
        bus.A     = a;
        bus.B     = b;
        bus.Sel   = sel;
        bus.start = 1'b1;
    endtask

    // Waits (bounded) for a done pulse; optionally drops start after the first edge.
    task automatic wait_done(input bit drop_start, output int edges, output int busy_cycles, output bit seen);
        edges       = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (drop_start) bus.start = 1'b0;
            if (bus.busy) busy_cycles++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Sel   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ctrl: busy/done=%b required 00", {bus.busy, bus.done});
        end
        tests++;
        if (observed() !== exp_t'('0)) begin
            fails++;
            $display("FAIL reset_result: got %h required %h", observed(), exp_t'('0));
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'h5A, 8'h3C, 8'h80, 8'h7F, 8'hFF};
        logic [W-1:0] tb [5] = '{8'h3C, 8'h5A, 8'h01, 8'h01, 8'h01};
        logic         ts [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t         te [5] = '{
            '{8'h1E, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'hE2, 1'b0, 1'b0, 1'b1, 1'b0},
            '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1},
            '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1},
            '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}
        };
        int   edges;
        int   busy_cycles;
        bit   seen;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(te[i]);
            drive_op(ta[i], tb[i], ts[i]);
            wait_done(1'b1, edges, busy_cycles, seen);
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL directed%0d_timeout: no done within %0d edges", i, edges);
                void'(sb.pop_front());
            end else begin
                tests++;
                if (edges != K + 1) begin
                    fails++;
                    $display("FAIL directed%0d_latency: done after %0d edges required %0d", i, edges, K + 1);
                end
                tests++;
                if (busy_cycles != K) begin
                    fails++;
                    $display("FAIL directed%0d_busy: busy for %0d cycles required %0d", i, busy_cycles, K);
                end
                e = sb.pop_front();
                tests++;
                if (observed() !== e) begin
                    fails++;
                    $display("FAIL directed%0d_result: got %h required %h", i, observed(), e);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.done !== 1'b0 || observed() !== te[i]) begin
                fails++;
                $display("FAIL directed%0d_hold: done=%b result=%h required done=0 result=%h",
                         i, bus.done, observed(), te[i]);
            end
        end
    endtask

    task automatic test_ignore_start_in_run();
        int   dones = 0;
        exp_t e;
        sb.push_back('{8'h46, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_op(8'h12, 8'h34, OP_ADD);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        drive_op(8'hFF, 8'h0F, OP_SUB);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    tests++;
                    if (observed() !== e) begin
                        fails++;
                        $display("FAIL ignore_result: got %h required %h", observed(), e);
                    end
                end
            end
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL ignore_done_count: %0d done pulses required 1", dones);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int   edges;
        int   busy_cycles;
        bit   seen;
        exp_t e;
        sb.push_back('{8'h1E, 1'b1, 1'b0, 1'b0, 1'b0});
        sb.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 1'b1});
        drive_op(8'h5A, 8'h3C, OP_SUB);
        wait_done(1'b0, edges, busy_cycles, seen);
        tests++;
        if (!seen || edges != K + 1) begin
            fails++;
            $display("FAIL b2b_first_latency: seen=%0d edges=%0d required seen=1 edges=%0d", seen, edges, K + 1);
        end
        e = sb.pop_front();
        tests++;
        if (observed() !== e) begin
            fails++;
            $display("FAIL b2b_first_result: got %h required %h", observed(), e);
        end
        // start stays high through DONE; new operands are taken on that edge
        drive_op(8'h7F, 8'h01, OP_ADD);
        wait_done(1'b1, edges, busy_cycles, seen);
        tests++;
        if (!seen || edges != K + 1) begin
            fails++;
            $display("FAIL b2b_second_latency: seen=%0d edges=%0d required seen=1 edges=%0d", seen, edges, K + 1);
        end
        e = sb.pop_front();
        tests++;
        if (observed() !== e) begin
            fails++;
            $display("FAIL b2b_second_result: got %h required %h", observed(), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int   dones = 0;
        int   edges;
        int   busy_cycles;
        bit   seen;
        exp_t e;
        drive_op(8'h5A, 8'h3C, OP_SUB);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.done} !== 2'b00 || observed() !== exp_t'('0)) begin
            fails++;
            $display("FAIL abort_outputs: busy/done=%b result=%h required 00 and %h",
                     {bus.busy, bus.done}, observed(), exp_t'('0));
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL abort_no_done: %0d done pulses required 0", dones);
        end
        sb.push_back('{8'hE2, 1'b0, 1'b0, 1'b1, 1'b0});
        drive_op(8'h3C, 8'h5A, OP_SUB);
        wait_done(1'b1, edges, busy_cycles, seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL abort_fresh_timeout: no done within %0d edges", edges);
            sb.delete();
        end else begin
            e = sb.pop_front();
            tests++;
            if (observed() !== e) begin
                fails++;
                $display("FAIL abort_fresh_result: got %h required %h", observed(), e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        exp_t         last;
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        bit           seen;
        last = observed();
        for (int n = 0; n < 10000; n++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            sel = 1'($urandom_range(0, 1));
            sb.push_back(model(a, b, sel));
            drive_op(a, b, sel);
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (bus.busy && bus.done) begin
                    tests++;
                    fails++;
                    $display("FAIL rand_busy_done: both high in op %0d", n);
                end
                if (bus.done) begin
                    seen = 1'b1;
                end else begin
                    tests++;
                    if (observed() !== last) begin
                        fails++;
                        $display("FAIL rand_hold: op %0d result %h changed from %h", n, observed(), last);
                    end
                end
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL rand_timeout: op %0d no done", n);
                break;
            end
            e = sb.pop_front();
            tests++;
            if (observed() !== e) begin
                fails++;
                $display("FAIL rand_result: op %0d A=%h B=%h Sel=%b got %h required %h",
                         n, a, b, sel, observed(), e);
            end
            last = observed();
        end
        bus.start = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start_in_run();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
